// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding selects, load-use / branch-load stall
// sequencing, data-memory wait stalls, IF-ID flush and a saturating stall counter.
module hazard_ctrl #(
    parameter int REG_AW      = 4,
    parameter int ZERO_REG_EN = 1,
    parameter int LOAD_LAT    = 1,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] rr1_d,
    input  logic [REG_AW-1:0] rr2_d,
    input  logic              mem_wr_d,
    input  logic              br_d,
    input  logic              br_taken_d,
    input  logic [REG_AW-1:0] rr1_x,
    input  logic [REG_AW-1:0] rr2_x,
    input  logic              wr_en_x,
    input  logic              wr_en_m,
    input  logic              wr_en_w,
    input  logic [REG_AW-1:0] wr_reg_x,
    input  logic [REG_AW-1:0] wr_reg_m,
    input  logic [REG_AW-1:0] wr_reg_w,
    input  logic              mem_to_reg_x,
    input  logic              mem_to_reg_m,
    input  logic              mem_wr_m,
    input  logic              dmem_busy,
    output logic              stall_f,
    output logic              stall_d,
    output logic              stall_x,
    output logic              stall_m,
    output logic              bubble_x,
    output logic              flush_d,
    output logic [1:0]        fwd_d,
    output logic [1:0]        fwd_a_x,
    output logic [1:0]        fwd_b_x,
    output logic              fwd_m,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    // Counter holds the number of LU_STALL cycles still to run after the detecting cycle.
    localparam logic [2:0] LU_INIT = 3'(LOAD_LAT - 1);

    state_t           r_state;
    state_t           w_state_nx;
    logic [2:0]       r_lu_cnt;
    logic [2:0]       w_lu_cnt_nx;
    logic [CNT_W-1:0] r_stall_cnt;
    logic             w_hz_lu;
    logic             w_hz_br;

    function automatic logic f_match(input logic en, input logic [REG_AW-1:0] wr,
                                     input logic [REG_AW-1:0] src);
        return en && (wr == src) && ((ZERO_REG_EN == 0) || (wr != '0));
    endfunction

    always_comb begin
        fwd_a_x = f_match(wr_en_m, wr_reg_m, rr1_x) ? 2'b01 :
                  f_match(wr_en_w, wr_reg_w, rr1_x) ? 2'b10 : 2'b00;
        fwd_b_x = f_match(wr_en_m, wr_reg_m, rr2_x) ? 2'b01 :
                  f_match(wr_en_w, wr_reg_w, rr2_x) ? 2'b10 : 2'b00;
        fwd_d   = f_match(wr_en_x, wr_reg_x, rr1_d) ? 2'b01 :
                  f_match(wr_en_m, wr_reg_m, rr1_d) ? 2'b10 :
                  f_match(wr_en_w, wr_reg_w, rr1_d) ? 2'b11 : 2'b00;
        // wr_reg_m carries the MEM store's data-source register.
        fwd_m   = mem_wr_m && f_match(wr_en_w, wr_reg_w, wr_reg_m);
    end

    assign w_hz_lu = mem_to_reg_x &&
                     (f_match(wr_en_x, wr_reg_x, rr1_d) ||
                      (f_match(wr_en_x, wr_reg_x, rr2_d) && !mem_wr_d));
    assign w_hz_br = br_d && mem_to_reg_m && f_match(wr_en_m, wr_reg_m, rr1_d);

    // NOTE: every output and next-state value gets a default first so no latch is inferred.
    always_comb begin
        w_state_nx  = r_state;
        w_lu_cnt_nx = r_lu_cnt;
        stall_f     = 1'b0;
        stall_d     = 1'b0;
        stall_x     = 1'b0;
        stall_m     = 1'b0;
        bubble_x    = 1'b0;
        unique case (r_state)
            RUN: begin
                if (dmem_busy) begin
                    w_state_nx = MEM_WAIT;
                    {stall_f, stall_d, stall_x, stall_m} = 4'b1111;
                end else if (w_hz_lu || w_hz_br) begin
                    {stall_f, stall_d, bubble_x} = 3'b111;
                    if (LOAD_LAT > 1) begin
                        w_state_nx  = LU_STALL;
                        w_lu_cnt_nx = LU_INIT;
                    end
                end
            end
            LU_STALL: begin
                {stall_f, stall_d, bubble_x} = 3'b111;
                if (dmem_busy) begin
                    w_state_nx  = MEM_WAIT;
                    w_lu_cnt_nx = 3'd0;
                end else if (r_lu_cnt <= 3'd1) begin
                    w_state_nx  = RUN;
                    w_lu_cnt_nx = 3'd0;
                end else begin
                    w_lu_cnt_nx = r_lu_cnt - 3'd1;
                end
            end
            MEM_WAIT: begin
                {stall_f, stall_d, stall_x, stall_m} = 4'b1111;
                if (!dmem_busy) w_state_nx = RUN;
            end
            default: w_state_nx = RUN;
        endcase
        if (rst) begin
            {stall_f, stall_d, stall_x, stall_m, bubble_x} = 5'b0;
        end
        // A taken branch seen while D is held is replayed, not flushed.
        flush_d = br_taken_d && !stall_d && !rst;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= RUN;
            r_lu_cnt    <= 3'd0;
            r_stall_cnt <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_lu_cnt <= w_lu_cnt_nx;
            if (stall_f && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (LOAD_LAT 1 and 3) on shared inputs, directed
// scenarios followed by random traffic, all checked against a cycle-count reference model.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] rr1_d, rr2_d, rr1_x, rr2_x, wr_reg_x, wr_reg_m, wr_reg_w;
    logic       mem_wr_d, br_d, br_taken_d, wr_en_x, wr_en_m, wr_en_w;
    logic       mem_to_reg_x, mem_to_reg_m, mem_wr_m, dmem_busy;

    logic        o0_stall_f, o0_stall_d, o0_stall_x, o0_stall_m, o0_bubble_x, o0_flush_d, o0_fwd_m;
    logic [1:0]  o0_fwd_d, o0_fwd_a_x, o0_fwd_b_x;
    logic [15:0] o0_stall_cnt;
    logic        o1_stall_f, o1_stall_d, o1_stall_x, o1_stall_m, o1_bubble_x, o1_flush_d, o1_fwd_m;
    logic [1:0]  o1_fwd_d, o1_fwd_a_x, o1_fwd_b_x;
    logic [15:0] o1_stall_cnt;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: per instance, pending memory wait, LU cycles left, stall count.
    int lat   [2] = '{1, 3};
    bit m_wait[2];
    int m_left[2];
    int m_cnt [2];

    always #5 clk = ~clk;

    hazard_ctrl #(.REG_AW(4), .ZERO_REG_EN(1), .LOAD_LAT(1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .rr1_d(rr1_d), .rr2_d(rr2_d), .mem_wr_d(mem_wr_d), .br_d(br_d),
        .br_taken_d(br_taken_d), .rr1_x(rr1_x), .rr2_x(rr2_x), .wr_en_x(wr_en_x),
        .wr_en_m(wr_en_m), .wr_en_w(wr_en_w), .wr_reg_x(wr_reg_x), .wr_reg_m(wr_reg_m),
        .wr_reg_w(wr_reg_w), .mem_to_reg_x(mem_to_reg_x), .mem_to_reg_m(mem_to_reg_m),
        .mem_wr_m(mem_wr_m), .dmem_busy(dmem_busy), .stall_f(o0_stall_f), .stall_d(o0_stall_d),
        .stall_x(o0_stall_x), .stall_m(o0_stall_m), .bubble_x(o0_bubble_x), .flush_d(o0_flush_d),
        .fwd_d(o0_fwd_d), .fwd_a_x(o0_fwd_a_x), .fwd_b_x(o0_fwd_b_x), .fwd_m(o0_fwd_m),
        .stall_cnt(o0_stall_cnt)
    );

    hazard_ctrl #(.REG_AW(4), .ZERO_REG_EN(1), .LOAD_LAT(3), .CNT_W(16)) dut3 (
        .clk(clk), .rst(rst), .rr1_d(rr1_d), .rr2_d(rr2_d), .mem_wr_d(mem_wr_d), .br_d(br_d),
        .br_taken_d(br_taken_d), .rr1_x(rr1_x), .rr2_x(rr2_x), .wr_en_x(wr_en_x),
        .wr_en_m(wr_en_m), .wr_en_w(wr_en_w), .wr_reg_x(wr_reg_x), .wr_reg_m(wr_reg_m),
        .wr_reg_w(wr_reg_w), .mem_to_reg_x(mem_to_reg_x), .mem_to_reg_m(mem_to_reg_m),
        .mem_wr_m(mem_wr_m), .dmem_busy(dmem_busy), .stall_f(o1_stall_f), .stall_d(o1_stall_d),
        .stall_x(o1_stall_x), .stall_m(o1_stall_m), .bubble_x(o1_bubble_x), .flush_d(o1_flush_d),
        .fwd_d(o1_fwd_d), .fwd_a_x(o1_fwd_a_x), .fwd_b_x(o1_fwd_b_x), .fwd_m(o1_fwd_m),
        .stall_cnt(o1_stall_cnt)
    );

    function automatic bit q(input bit en, input int w, input int s);
        return en && (w != 0) && (w == s);
    endfunction

    function automatic bit hazard();
        bit lu, br;
        lu = mem_to_reg_x && (q(wr_en_x, wr_reg_x, rr1_d) || (q(wr_en_x, wr_reg_x, rr2_d) && !mem_wr_d));
        br = br_d && mem_to_reg_m && q(wr_en_m, wr_reg_m, rr1_d);
        return lu || br;
    endfunction

    function automatic int sel_x(input int src);
        if (q(wr_en_m, wr_reg_m, src)) return 1;
        if (q(wr_en_w, wr_reg_w, src)) return 2;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected stall mode for instance k: 2 = full memory stall, 1 = load-use stall, 0 = none.
    function automatic int mode(input int k);
        if (rst) return 0;
        if (m_wait[k] || (m_left[k] == 0 && dmem_busy)) return 2;
        if (m_left[k] > 0 || hazard()) return 1;
        return 0;
    endfunction

    task automatic check_all(input string tag);
        logic [5:0] exp_v, obs_v;
        logic [6:0] exp_f, obs_f;
        int md, fd;
        fd = q(wr_en_x, wr_reg_x, rr1_d) ? 1 : q(wr_en_m, wr_reg_m, rr1_d) ? 2 :
             q(wr_en_w, wr_reg_w, rr1_d) ? 3 : 0;
        exp_f = {2'(fd), 2'(sel_x(rr1_x)), 2'(sel_x(rr2_x)),
                 1'(mem_wr_m && q(wr_en_w, wr_reg_w, wr_reg_m))};
        for (int k = 0; k < 2; k++) begin
            md = mode(k);
            exp_v = {md != 0, md != 0, md == 2, md == 2, md == 1, !rst && br_taken_d && md == 0};
            obs_v = (k == 0) ? {o0_stall_f, o0_stall_d, o0_stall_x, o0_stall_m, o0_bubble_x, o0_flush_d}
                             : {o1_stall_f, o1_stall_d, o1_stall_x, o1_stall_m, o1_bubble_x, o1_flush_d};
            obs_f = (k == 0) ? {o0_fwd_d, o0_fwd_a_x, o0_fwd_b_x, o0_fwd_m}
                             : {o1_fwd_d, o1_fwd_a_x, o1_fwd_b_x, o1_fwd_m};
            chk($sformatf("%s.ctl%0d", tag, k), 32'(obs_v), 32'(exp_v));
            chk($sformatf("%s.fwd%0d", tag, k), 32'(obs_f), 32'(exp_f));
            chk($sformatf("%s.cnt%0d", tag, k), 32'((k == 0) ? o0_stall_cnt : o1_stall_cnt), 32'(m_cnt[k]));
        end
    endtask

    task automatic update_model();
        int md;
        for (int k = 0; k < 2; k++) begin
            md = mode(k);
            if (rst) begin
                m_wait[k] = 0; m_left[k] = 0; m_cnt[k] = 0;
            end else begin
                if (md != 0 && m_cnt[k] < 65535) m_cnt[k]++;
                if (m_wait[k]) m_wait[k] = dmem_busy;
                else if (m_left[k] > 0) begin
                    if (dmem_busy) begin m_wait[k] = 1; m_left[k] = 0; end
                    else m_left[k]--;
                end else if (dmem_busy) m_wait[k] = 1;
                else if (hazard()) m_left[k] = lat[k] - 1;
            end
        end
    endtask

    task automatic step(input string tag);
        @(negedge clk);
        check_all(tag);
        @(posedge clk);
        update_model();
        #1;
    endtask

    task automatic idle_inputs();
        {rr1_d, rr2_d, rr1_x, rr2_x, wr_reg_x, wr_reg_m, wr_reg_w} = '0;
        {mem_wr_d, br_d, br_taken_d, wr_en_x, wr_en_m, wr_en_w} = '0;
        {mem_to_reg_x, mem_to_reg_m, mem_wr_m, dmem_busy} = '0;
    endtask

    task automatic load_use(input logic [3:0] r);
        mem_to_reg_x = 1'b1; wr_en_x = 1'b1; wr_reg_x = r; rr1_d = r;
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        for (int k = 0; k < 2; k++) begin m_wait[k] = 0; m_left[k] = 0; m_cnt[k] = 0; end
        @(posedge clk); #1;
        br_taken_d = 1'b1;
        step("reset");
        rst = 1'b0;
        step("idle_flush");

        // Load r3 in EX, dependent read in D; branch taken is held while stalled.
        load_use(4'd3);
        step("lu_detect");
        idle_inputs();
        mem_to_reg_m = 1'b1; wr_en_m = 1'b1; wr_reg_m = 4'd3; br_taken_d = 1'b1;
        for (int i = 0; i < 3; i++) step("lu_tail");
        idle_inputs();
        step("lu_done");
        chk("lu_cnt_lat1", 32'(o0_stall_cnt), 32'd1);
        chk("lu_cnt_lat3", 32'(o1_stall_cnt), 32'd3);

        // Branch reading a register loaded by the MEM stage.
        br_d = 1'b1; mem_to_reg_m = 1'b1; wr_en_m = 1'b1; wr_reg_m = 4'd6; rr1_d = 4'd6;
        step("br_load");
        idle_inputs();
        for (int i = 0; i < 3; i++) step("br_tail");

        // Store data from a loaded register: no stall, later WB->MEM store forwarding.
        mem_to_reg_x = 1'b1; wr_en_x = 1'b1; wr_reg_x = 4'd5; mem_wr_d = 1'b1; rr2_d = 4'd5;
        step("ld_st");
        chk("ld_st_nostall", 32'(o1_stall_f), 32'd0);
        idle_inputs();
        mem_wr_m = 1'b1; wr_reg_m = 4'd5; wr_en_w = 1'b1; wr_reg_w = 4'd5;
        step("st_fwd");
        chk("fwd_m_wb", 32'(o0_fwd_m), 32'd1);

        // MEM beats WB; index 0 never forwards.
        idle_inputs();
        wr_en_m = 1'b1; wr_en_w = 1'b1; wr_reg_m = 4'd7; wr_reg_w = 4'd7; rr1_x = 4'd7;
        step("fwd_prio");
        chk("fwd_a_mem", 32'(o0_fwd_a_x), 32'd1);
        wr_reg_m = 4'd2;
        step("fwd_wb");
        chk("fwd_a_wb", 32'(o0_fwd_a_x), 32'd2);
        wr_reg_m = 4'd0; wr_reg_w = 4'd0; rr1_x = 4'd0;
        step("fwd_zero");
        chk("fwd_a_zero", 32'(o0_fwd_a_x), 32'd0);

        // Memory busy for 4 cycles starting inside a load-use stall.
        idle_inputs();
        load_use(4'd9);
        step("busy_detect");
        idle_inputs();
        step("busy_lu1");
        dmem_busy = 1'b1;
        for (int i = 0; i < 4; i++) step("busy_wait");
        dmem_busy = 1'b0;
        step("busy_release");
        step("busy_run");

        // Reset in the second load-use stall cycle.
        load_use(4'd4);
        step("rst_detect");
        idle_inputs();
        step("rst_lu1");
        rst = 1'b1;
        step("rst_lu2");
        rst = 1'b0;
        step("rst_after");
        chk("rst_cnt_cleared", 32'(o1_stall_cnt), 32'd0);

        // Random traffic over a small register space to provoke frequent matches.
        for (int i = 0; i < 400; i++) begin
            rr1_d = 4'($urandom_range(0, 3));      rr2_d = 4'($urandom_range(0, 3));
            rr1_x = 4'($urandom_range(0, 3));      rr2_x = 4'($urandom_range(0, 3));
            wr_reg_x = 4'($urandom_range(0, 3));   wr_reg_m = 4'($urandom_range(0, 3));
            wr_reg_w = 4'($urandom_range(0, 3));
            {mem_wr_d, br_d, br_taken_d, wr_en_x, wr_en_m, wr_en_w} = 6'($urandom);
            mem_to_reg_x = ($urandom_range(0, 99) < 40);
            mem_to_reg_m = ($urandom_range(0, 99) < 40);
            mem_wr_m     = $urandom_range(0, 1) == 1;
            dmem_busy    = ($urandom_range(0, 99) < 12);
            rst          = ($urandom_range(0, 99) < 2);
            step("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
